// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the riscv_mem_responder memory slave.
// The MEM_RAND_WAIT_EN build option uses the LFSR helpers defined here.
package riscv_mem_pkg;

    // Responder FSM: accept in IDLE, count wait states in WAIT,
    // present the one-cycle mem_ready strobe in RESP.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Holds WAIT_CYCLES (max 15) plus the optional random extra (max 3).
    localparam int WAIT_W = 5;

    // Fibonacci taps 16,14,13,11 expressed as a mask over lfsr[15:0].
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Read data returned for addresses outside the RAM window.
    localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

    // A bus request as captured at acceptance.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
    } req_t;

    // One shift of the Fibonacci LFSR: feedback is the parity of the tapped bits.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/riscv_mem_wait_lfsr.sv
// Pseudo-random wait-state generator for riscv_mem_responder.
// Only built when MEM_RAND_WAIT_EN is defined; otherwise this file is empty
// so the default build carries no LFSR logic at all.
`ifdef MEM_RAND_WAIT_EN
module riscv_mem_wait_lfsr
    import riscv_mem_pkg::*;
#(
    parameter int          WAIT_CYCLES = 0,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              advance,
    output logic [WAIT_W-1:0] wait_val
);

    logic [15:0] lfsr;

    // Step the LFSR once per accepted request; reseed on reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr <= LFSR_SEED;
        end else if (advance) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    // The wait for the request being accepted uses the pre-advance state.
    assign wait_val = WAIT_W'(WAIT_CYCLES) + WAIT_W'(lfsr[1:0]);

    // Only the two low bits feed the wait value; the rest is shift history.
    logic unused_lfsr;
    assign unused_lfsr = ^lfsr[15:2];

endmodule
`endif

// File: rtl/riscv_mem_responder.sv
// Memory slave for the RISC-V core's native valid/ready bus, backed by a
// word-addressed RAM with byte-strobe writes, fixed wait states,
// out-of-range detection, protocol-error detection and transaction counters.
// Build option: define MEM_RAND_WAIT_EN to add 0..3 pseudo-random extra
// wait states per request (riscv_mem_wait_lfsr).
module riscv_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int          MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] ERR_RDATA   = DEFAULT_ERR_RDATA,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        oor_err,
    output logic        proto_err,
    output logic [31:0] txn_count,
    output logic [31:0] ifetch_count
);

    localparam int AW = $clog2(MEM_WORDS);

    state_t            state;
    state_t            state_nxt;
    req_t              req_in;
    req_t              req_q;
    req_t              req_cur;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_val;

    logic              accept;
    logic              commit;
    logic              abort;

    logic [31:0]       byte_off;
    logic [31:0]       word_off;
    logic              in_range;
    logic [AW-1:0]     word_idx;
    logic              is_write;
    logic              ram_we;
    logic [31:0]       ram_rd;

    logic [31:0]       ram [MEM_WORDS];

    // ------------------------------------------------------------------
    // Request selection and address decode
    // ------------------------------------------------------------------
    assign req_in = '{addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb, instr: mem_instr};

    // With zero wait the access commits on the accepting edge, so the live
    // bus fields are used; from WAIT only the captured copy counts.
    assign req_cur  = (state == IDLE) ? req_in : req_q;

    // Subtraction wraps for addresses below BASE_ADDR, which then land far
    // above MEM_WORDS and are flagged out of range like any other miss.
    assign byte_off = req_cur.addr - BASE_ADDR;
    assign word_off = {2'b00, byte_off[31:2]};
    assign in_range = (word_off < 32'(MEM_WORDS));
    assign word_idx = word_off[AW-1:0];
    assign is_write = |req_cur.wstrb;
    assign ram_rd   = ram[word_idx];

    // ------------------------------------------------------------------
    // Wait-state source
    // ------------------------------------------------------------------
    logic unused_bits;

`ifdef MEM_RAND_WAIT_EN
    riscv_mem_wait_lfsr #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .LFSR_SEED   (LFSR_SEED)
    ) u_wait_lfsr (
        .clk      (clk),
        .resetn   (resetn),
        .advance  (accept),
        .wait_val (wait_val)
    );
    assign unused_bits = ^{byte_off[1:0], req_cur.instr};
`else
    assign wait_val    = WAIT_W'(WAIT_CYCLES);
    assign unused_bits = ^{byte_off[1:0], req_cur.instr, LFSR_SEED};
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // Next-state and per-edge action strobes (accept / commit / abort).
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        commit    = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_valid) begin
                    accept = 1'b1;
                    if (wait_val == '0) begin
                        commit    = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                // A request withdrawn before completion is a protocol error;
                // this takes priority over the final countdown step.
                if (!mem_valid) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_cnt == WAIT_W'(1)) begin
                    commit    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register, request capture, response, sticky flags and counters.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            req_q        <= '0;
            wait_cnt     <= '0;
            mem_ready    <= 1'b0;
            mem_rdata    <= '0;
            oor_err      <= 1'b0;
            proto_err    <= 1'b0;
            txn_count    <= '0;
            ifetch_count <= '0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                req_q    <= req_in;
                wait_cnt <= wait_val;
            end else if (state == WAIT) begin
                wait_cnt <= abort ? '0 : wait_cnt - WAIT_W'(1);
            end

            // mem_ready is high only in the cycle following a commit.
            mem_ready <= commit;

            if (commit) begin
                if (is_write) begin
                    mem_rdata <= '0;
                end else if (in_range) begin
                    mem_rdata <= ram_rd;
                end else begin
                    mem_rdata <= ERR_RDATA;
                end
                if (!in_range) begin
                    oor_err <= 1'b1;
                end
            end

            if (abort) begin
                proto_err <= 1'b1;
            end

            // The handshake completes on the edge that leaves RESP.
            if (state == RESP) begin
                txn_count <= txn_count + 32'd1;
                if (req_q.instr) begin
                    ifetch_count <= ifetch_count + 32'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // RAM
    // ------------------------------------------------------------------

    // Gating with resetn keeps an edge that arrives while reset is held from
    // committing the still-uncommitted request.
    assign ram_we = commit && is_write && in_range && resetn;

    // Byte-strobed write port.
    // NOTE: the RAM array is deliberately not reset so it maps onto RAM
    // primitives; its contents survive resetn.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (req_cur.wstrb[b]) begin
                    ram[word_idx][8*b +: 8] <= req_cur.wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: doc/riscv_mem_responder.md
Name: riscv_mem_responder

Overview:
- Synthesizable memory slave on the RISC-V core's native memory bus (valid/ready, 32-bit address and data, byte strobes).
- Sits directly downstream of the core's memory port and answers instruction and data requests from a local word-addressed RAM.
- Has configurable wait states, byte-strobe writes, out-of-range detection and a transaction counter.
- Gives the bench and FPGA builds a real memory that produces the mem_ready/mem_rdata side of the bus.

Parameters:
- MEM_WORDS, 1024: RAM depth in 32-bit words; power of two, at least 4.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to MEM_WORDS*4.
- WAIT_CYCLES, 0: fixed extra cycles before mem_ready; range 0..15.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned for out-of-range reads.
- LFSR_SEED, 16'hACE1: nonzero seed, used only with MEM_RAND_WAIT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- mem_valid  in  1  request valid from core.
- mem_instr  in  1  request is an instruction fetch; counted only.
- mem_addr  in  32  byte address; bits [1:0] ignored.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte write enables; 4'b0000 = read.
- mem_ready  out  1  single-cycle completion strobe.
- mem_rdata  out  32  read data, valid while mem_ready=1.
- oor_err  out  1  sticky flag: an out-of-range access occurred.
- proto_err  out  1  sticky flag: mem_valid dropped before mem_ready.
- txn_count  out  32  completed handshakes, wraps at 2^32.
- ifetch_count  out  32  completed handshakes with mem_instr=1, wraps.

Behaviour:
- Reset (resetn=0, async): state IDLE, mem_ready=0, mem_rdata=0, oor_err=0, proto_err=0, txn_count=0, ifetch_count=0, wait counter=0. RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE, on an edge E with mem_valid=1: latch addr/wdata/wstrb/instr.
  - If wait=0, commit the access and go to RESP.
  - Otherwise load the counter with wait and go to WAIT.
- WAIT: decrement the counter each edge. When the counter reaches 1 and mem_valid=1, commit the access and go to RESP.
- Commit, on the same edge that sets mem_ready=1:
  - In range: word index = (addr - BASE_ADDR)>>2 < MEM_WORDS.
  - Write: update only the bytes whose wstrb bit is set; mem_rdata=0.
  - Read: mem_rdata = RAM[index].
  - Out of range: write dropped, read returns ERR_RDATA, oor_err set.
- RESP: mem_ready=1 for exactly one cycle.
  - On that edge: txn_count+1, ifetch_count+1 if instr, mem_ready cleared, mem_rdata held, next state IDLE.
  - A new request can be accepted on the edge after RESP, so back-to-back handshakes come one per (2+wait) cycles.
- Latency: the handshake completes (mem_ready sampled high) at edge E+1+wait, where wait=WAIT_CYCLES.
- mem_valid low while in WAIT:
  - Abort, no write, set proto_err, go to IDLE, counters unchanged.
- Request fields are latched at acceptance. Later changes to mem_addr/mem_wdata/mem_wstrb are ignored.
- Reset mid-transaction: an uncommitted write is never performed, and mem_ready drops immediately.
- Read-after-write to the same word in back-to-back transactions returns the new data.

Optional Feature:
- Macro: MEM_RAND_WAIT_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded with LFSR_SEED at reset and advances once per accepted request.
  - wait = WAIT_CYCLES + lfsr[1:0], range WAIT_CYCLES..WAIT_CYCLES+3.
- Not defined: no LFSR logic; wait = WAIT_CYCLES exactly.

Decomposition:
- Package riscv_mem_pkg:
  - state enum (IDLE, WAIT, RESP)
  - WAIT_W=5 counter width
  - LFSR_TAPS constant
  - default ERR_RDATA
- Sub-module riscv_mem_wait_lfsr:
  - LFSR plus wait computation (enable = accept pulse, output wait value).
  - Instantiated only under MEM_RAND_WAIT_EN.

Test Plan:
- WAIT_CYCLES=0: write 32'h1234_5678 with wstrb=4'hF to 0x10, then read 0x10 → mem_ready one cycle after each request, rdata 32'h1234_5678, txn_count=2.
- Byte strobes: word 0x20=32'hAABB_CCDD, write 32'h1122_3344 with wstrb=4'b0101 → read returns 32'hAA22_CC44.
- WAIT_CYCLES=3: read request at edge E → mem_ready sampled high only at E+4, low at E+1..E+3.
- Out-of-range read at BASE_ADDR+MEM_WORDS*4 → rdata 32'hDEAD_BEEF, oor_err=1 stays set. A write there leaves all RAM words unchanged.
- WAIT_CYCLES=2: drop mem_valid after 1 WAIT cycle → no mem_ready, proto_err=1, write not committed, txn_count unchanged.
- Assert resetn=0 during WAIT of a write → mem_ready=0 immediately, counters 0, target word keeps its old value.
